alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
// - Shares one 32-bit ALU datapath (ADD/SUB/SLT/SLTU/XOR/OR/AND/SLL/SRL/SRA)
//   between NUM_REQ requesters, e.g. the main execute path and an address-gen unit.
// - Requests are arbitrated round-robin; the selected operation is computed and
//   registered, then returned with the requester ID over a valid/ready response port.
// - Sits between the decode/issue stage and the ALU operators in the single-cycle core.
// PARAMETERS
// - NUM_REQ  default 2   number of requesters (2..8)
// - ID_W     default 1   width of o_rsp_id; must equal $clog2(NUM_REQ)
// PORTS
// - i_clk        in   1            clock; all logic on the rising edge
// - i_rst_n      in   1            synchronous active-low reset
// - i_req_valid  in   NUM_REQ      per-requester request valid
// - o_req_ready  out  NUM_REQ      per-requester accept; one-hot or zero
// - i_req_op     in   NUM_REQ*4    per-requester alu_op_e; slot i at [4i+3:4i]
// - i_req_a      in   NUM_REQ*32   per-requester operand A
// - i_req_b      in   NUM_REQ*32   per-requester operand B
// - o_rsp_valid  out  1            response holds a result
// - i_rsp_ready  in   1            consumer accepts the response
// - o_rsp_result out  32           ALU result
// - o_rsp_id     out  ID_W         index of the requester that owns the result
// - o_rsp_err    out  1            op code not defined in alu_op_e
// BEHAVIOUR
// - Reset: o_rsp_valid=0, o_rsp_result=0, o_rsp_id=0, o_rsp_err=0, rr pointer=0,
//   state=S_EMPTY. Reset mid-operation drops any held response.
// - FSM: S_EMPTY (no result held) and S_FULL (result held, o_rsp_valid=1).
// - can_accept = (state==S_EMPTY) | i_rsp_ready. This is a full-throughput pipeline.
// - Grant: the first requester with valid=1, searching from the rr pointer upward
//   modulo NUM_REQ. o_req_ready[g] = can_accept & grant[g]. All other bits are 0.
// - Handshake on (valid & ready): the ALU computes on the granted operands in the same
//   cycle; result, ID and err are registered at the next edge; the rr pointer
//   becomes (g+1) mod NUM_REQ. Latency from accept to o_rsp_valid is 1 cycle.
// - No accept: the pointer holds.
// - S_EMPTY->S_FULL on accept.
// - S_FULL->S_EMPTY on i_rsp_ready without a new accept.
// - S_FULL->S_FULL on i_rsp_ready with a new accept (back-to-back).
// - S_FULL with i_rsp_ready=0: all outputs are stable and every o_req_ready bit is 0.
// - Requesters hold op/a/b stable while valid=1 and ready=0. A requester may not
//   drop valid before it is accepted.
// - Arithmetic: wrap modulo 2^32, no overflow flag. SLT is signed and SLTU is unsigned;
//   both return 32'h0/32'h1. Shifts use b[4:0] only. SRA sign-fills.
// - Undefined op: result=0 and err=1. It is still a normal accept and response.
// CONFIGURATION
// - Macro ALU_SHARE_ARBITER_STATS_EN.
// - Defined: adds output o_grant_cnt (NUM_REQ*16) holding one saturating 16-bit grant
//   counter per requester. A counter increments on each accept of its requester and
//   sticks at 16'hFFFF. Counters clear on reset.
// - Not defined: the port and the counters are absent. All other behaviour is identical.
// STRUCTURE
// - Package alu_pkg holds alu_op_e (4-bit enum: ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4,
//   OR=5, AND=6, SLL=7, SRL=8, SRA=9), localparam XLEN=32, and the arb state enum.
// - Sub-module alu_rr_picker: combinational round-robin one-hot grant from
//   (i_valid, i_ptr) -> (o_grant, o_idx).
// - The ALU operators are instantiated in this module behind a single op mux.
// TESTING
// - Reset: hold i_rst_n=0 for 3 cycles with requests active -> o_rsp_valid=0,
//   o_req_ready=0, o_rsp_result=0.
// - Single request: req0 OR a=32'hF0F0_0000 b=32'h0000_0F0F -> one cycle later
//   o_rsp_valid=1, result=32'hF0F0_0F0F, id=0, err=0.
// - Contention: req0 and req1 both valid and i_rsp_ready=1 -> grants alternate
//   0,1,0,1. req1 SUB 5-7 returns 32'hFFFF_FFFE with id=1.
// - Backpressure: i_rsp_ready=0 for 4 cycles while S_FULL -> result, id and valid are
//   stable and o_req_ready=0. Release -> the next grant comes the same cycle, with no bubble.
// - Edge ops: SLT 32'h8000_0000 vs 1 -> 1. SLTU of the same -> 0.
//   SRA 32'h8000_0000 by b=32'h21 -> 32'hC000_0000. Op 4'hF -> result 0, err=1.
// - Stats (macro defined): 70000 accepts on req0 -> counter 0 = 16'hFFFF, counter 1
//   unchanged. Reset clears both counters.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU share arbiter: ALU op codes, datapath width and arbiter states.
package alu_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      OpAdd  = 4'd0,
      OpSub  = 4'd1,
      OpSlt  = 4'd2,
      OpSltu = 4'd3,
      OpXor  = 4'd4,
      OpOr   = 4'd5,
      OpAnd  = 4'd6,
      OpSll  = 4'd7,
      OpSrl  = 4'd8,
      OpSra  = 4'd9
   } alu_op_e;

   typedef enum logic {
      SEmpty,
      SFull
   } arb_state_e;

endpackage

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first valid requester at or above i_ptr, modulo NUM_REQ.
module alu_rr_picker
   import alu_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx
);

   always_comb begin
      int unsigned idx;
      logic        found;
      idx     = 0;
      found   = 1'b0;
      o_grant = '0;
      o_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(i_ptr) + k) % NUM_REQ;
         if (!found && i_valid[idx[ID_W-1:0]]) begin
            found                  = 1'b1;
            o_grant[idx[ID_W-1:0]] = 1'b1;
            o_idx                  = idx[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin shared ALU with a one-entry registered response stage.
// Optional per-requester grant counters under ALU_SHARE_ARBITER_STATS_EN.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [NUM_REQ-1:0]      i_req_valid,
   output logic [NUM_REQ-1:0]      o_req_ready,
   input  logic [NUM_REQ*4-1:0]    i_req_op,
   input  logic [NUM_REQ*XLEN-1:0] i_req_a,
   input  logic [NUM_REQ*XLEN-1:0] i_req_b,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [XLEN-1:0]         o_rsp_result,
   output logic [ID_W-1:0]         o_rsp_id,
   output logic                    o_rsp_err
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,output logic [NUM_REQ*16-1:0]   o_grant_cnt
`endif
);

   arb_state_e          state_q;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     gnt_idx;
   logic                can_accept, accept;
   logic [3:0]          op_sel;
   logic [XLEN-1:0]     a_sel, b_sel, alu_res;
   logic                alu_err;

   alu_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .i_valid (i_req_valid),
      .i_ptr   (ptr_q),
      .o_grant (grant),
      .o_idx   (gnt_idx)
   );

   // Held in reset so no requester sees an accept that will be discarded.
   assign can_accept  = i_rst_n & ((state_q == SEmpty) | i_rsp_ready);
   assign accept      = can_accept & (|i_req_valid);
   assign o_req_ready = can_accept ? grant : '0;
   assign o_rsp_valid = (state_q == SFull);
   assign ptr_d       = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      op_sel = '0;
      a_sel  = '0;
      b_sel  = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (gnt_idx == ID_W'(i)) begin
            op_sel = i_req_op[i*4 +: 4];
            a_sel  = i_req_a[i*XLEN +: XLEN];
            b_sel  = i_req_b[i*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (op_sel)
         OpAdd:   alu_res = a_sel + b_sel;
         OpSub:   alu_res = a_sel - b_sel;
         OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(a_sel) < $signed(b_sel)};
         OpSltu:  alu_res = {{(XLEN-1){1'b0}}, a_sel < b_sel};
         OpXor:   alu_res = a_sel ^ b_sel;
         OpOr:    alu_res = a_sel | b_sel;
         OpAnd:   alu_res = a_sel & b_sel;
         OpSll:   alu_res = a_sel << b_sel[4:0];
         OpSrl:   alu_res = a_sel >> b_sel[4:0];
         OpSra:   alu_res = $signed(a_sel) >>> b_sel[4:0];
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= SEmpty;
         ptr_q        <= '0;
         o_rsp_result <= '0;
         o_rsp_id     <= '0;
         o_rsp_err    <= 1'b0;
      end else if (accept) begin
         state_q      <= SFull;
         ptr_q        <= ptr_d;
         o_rsp_result <= alu_res;
         o_rsp_id     <= gnt_idx;
         o_rsp_err    <= alu_err;
      end else if (i_rsp_ready) begin
         state_q      <= SEmpty;
      end
   end

`ifdef ALU_SHARE_ARBITER_STATS_EN
   logic [15:0] cnt_q [NUM_REQ];

   always_ff @(posedge i_clk) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (!i_rst_n) begin
            cnt_q[i] <= '0;
         end else if (o_req_ready[i] && i_req_valid[i] && cnt_q[i] != 16'hFFFF) begin
            cnt_q[i] <= cnt_q[i] + 16'd1;
         end
      end
   end

   for (genvar gi = 0; gi < int'(NUM_REQ); gi++) begin : g_cnt_out
      assign o_grant_cnt[gi*16 +: 16] = cnt_q[gi];
   end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vectors, contention/backpressure
// sequences and randomized traffic against a transaction-level reference model.
module tb_alu_share_arbiter;

   localparam int N   = 2;
   localparam int IDW = 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*4-1:0]  req_op;
   logic [N*32-1:0] req_a, req_b;
   logic            rsp_valid, rsp_ready, rsp_err;
   logic [31:0]     rsp_result;
   logic [IDW-1:0]  rsp_id;
`ifdef ALU_SHARE_ARBITER_STATS_EN
   logic [N*16-1:0] grant_cnt;
`endif

   always #5 clk = ~clk;

   alu_share_arbiter #(
      .NUM_REQ (N),
      .ID_W    (IDW)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_op     (req_op),
      .i_req_a      (req_a),
      .i_req_b      (req_b),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_result (rsp_result),
      .o_rsp_id     (rsp_id),
      .o_rsp_err    (rsp_err)
`ifdef ALU_SHARE_ARBITER_STATS_EN
     ,.o_grant_cnt  (grant_cnt)
`endif
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: one held response plus the round-robin pointer.
   logic        m_full;
   logic [31:0] m_res;
   int          m_id;
   logic        m_err;
   int          m_ptr;
   int          m_cnt [N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, output logic err);
      logic [63:0] ext;
      longint      sa, sb;
      int          sh;
      sh  = int'(b % 32);
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      err = 1'b0;
      case (op)
         4'd0: return a + b;
         4'd1: return a + ~b + 32'd1;
         4'd2: return (sa < sb) ? 32'd1 : 32'd0;
         4'd3: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
         4'd4: return a ^ b;
         4'd5: return a | b;
         4'd6: return a & b;
         4'd7: return a * (32'd1 << sh);
         4'd8: return a / (32'd1 << sh);
         4'd9: begin
            ext = {{32{a[31]}}, a} >> sh;
            return ext[31:0];
         end
         default: begin
            err = 1'b1;
            return 32'd0;
         end
      endcase
   endfunction

   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_full = 1'b0;
      m_res  = '0;
      m_id   = 0;
      m_err  = 1'b0;
      m_ptr  = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   // Inputs are set before entry (at negedge); checks at +1, model steps at posedge.
   task automatic do_cycle(output logic [N-1:0] acc);
      int          g;
      logic        can;
      logic [N-1:0] exp_rdy;
      logic        e;
      #1;
      can     = rst_n && (!m_full || rsp_ready);
      g       = pick(req_valid, m_ptr);
      exp_rdy = '0;
      if (can && g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_full));
      check("rsp_result", rsp_result, m_res);
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_err", 32'(rsp_err), 32'(m_err));
      acc = exp_rdy;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (can && g >= 0) begin
         m_full = 1'b1;
         m_res  = ref_alu(req_op[g*4 +: 4], req_a[g*32 +: 32], req_b[g*32 +: 32], e);
         m_err  = e;
         m_id   = g;
         m_ptr  = (g + 1) % N;
         if (m_cnt[g] < 65535) m_cnt[g]++;
      end else if (rsp_ready) begin
         m_full = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic v, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      req_valid[i]      = v;
      req_op[i*4 +: 4]  = op;
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
   endtask

   task automatic do_reset();
      logic [N-1:0] acc;
      rst_n = 1'b0;
      do_cycle(acc);
      do_cycle(acc);
      do_cycle(acc);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t vt [12];

   initial begin
      logic [N-1:0] acc;
      logic [N-1:0] exp_gnt [4];
      logic [31:0]  ra, rb;

      vt[0]  = '{4'd5, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0};
      vt[1]  = '{4'd1, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0};
      vt[2]  = '{4'd2, 32'h8000_0000, 32'd1,         32'd1,         1'b0};
      vt[3]  = '{4'd3, 32'h8000_0000, 32'd1,         32'd0,         1'b0};
      vt[4]  = '{4'd9, 32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0};
      vt[5]  = '{4'hF, 32'h1234_5678, 32'h1,         32'd0,         1'b1};
      vt[6]  = '{4'd0, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
      vt[7]  = '{4'd7, 32'd1,         32'd31,        32'h8000_0000, 1'b0};
      vt[8]  = '{4'd8, 32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0};
      vt[9]  = '{4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
      vt[10] = '{4'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0};
      vt[11] = '{4'hA, 32'd3,         32'd4,         32'd0,         1'b1};

      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      rst_n     = 1'b0;
      model_reset();

      // Reset held with both requesters active.
      set_req(0, 1'b1, 4'd0, 32'd1, 32'd2);
      set_req(1, 1'b1, 4'd1, 32'd3, 32'd4);
      @(posedge clk);
      @(negedge clk);
      do_reset();
      req_valid = '0;

      // Directed single-requester vectors on req0.
      rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         set_req(0, 1'b1, vt[i].op, vt[i].a, vt[i].b);
         do_cycle(acc);
         req_valid = '0;
         check("vec_valid", 32'(rsp_valid), 32'd1);
         check("vec_result", rsp_result, vt[i].exp);
         check("vec_err", 32'(rsp_err), 32'(vt[i].err));
         check("vec_id", 32'(rsp_id), 32'd0);
      end
      do_cycle(acc);

      // Contention: grants alternate from a freshly reset pointer.
      do_reset();
      exp_gnt[0] = 2'b01;
      exp_gnt[1] = 2'b10;
      exp_gnt[2] = 2'b01;
      exp_gnt[3] = 2'b10;
      set_req(0, 1'b1, 4'd0, 32'd10, 32'd20);
      set_req(1, 1'b1, 4'd1, 32'd5,  32'd7);
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("contend_gnt", 32'(req_ready), 32'(exp_gnt[i]));
         do_cycle(acc);
      end
      check("contend_result", rsp_result, 32'hFFFF_FFFE);
      check("contend_id", 32'(rsp_id), 32'd1);

      // Backpressure: held response is frozen and nobody is accepted.
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_cycle(acc);
         check("bp_ready", 32'(req_ready), 32'd0);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_result", rsp_result, 32'hFFFF_FFFE);
         check("bp_id", 32'(rsp_id), 32'd1);
      end
      rsp_ready = 1'b1;
      #1;
      check("release_gnt", 32'(req_ready), 32'd1);
      do_cycle(acc);
      check("release_result", rsp_result, 32'd30);
      check("release_id", 32'(rsp_id), 32'd0);
      req_valid = '0;
      do_cycle(acc);

      // Randomized traffic; unaccepted requests are held stable.
      acc = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !acc[i])) begin
               ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
               rb = ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(0, 40))) : $urandom;
               set_req(i, ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 11)), ra, rb);
            end
         end
         rsp_ready = ($urandom_range(0, 9) < 7);
         do_cycle(acc);
      end

`ifdef ALU_SHARE_ARBITER_STATS_EN
      req_valid = '0;
      rsp_ready = 1'b1;
      do_reset();
      check("cnt_reset0", 32'(grant_cnt[15:0]), 32'd0);
      set_req(1, 1'b1, 4'd0, 32'd1, 32'd1);
      do_cycle(acc);
      do_cycle(acc);
      do_cycle(acc);
      req_valid = '0;
      set_req(0, 1'b1, 4'd0, 32'd2, 32'd2);
      for (int i = 0; i < 70000; i++) begin
         @(posedge clk);
         if (m_cnt[0] < 65535) m_cnt[0]++;
      end
      @(negedge clk);
      req_valid = '0;
      check("cnt_sat0", 32'(grant_cnt[15:0]), 32'(m_cnt[0]));
      check("cnt_sat0_ffff", 32'(grant_cnt[15:0]), 32'h0000_FFFF);
      check("cnt_keep1", 32'(grant_cnt[31:16]), 32'(m_cnt[1]));
      do_reset();
      check("cnt_clr0", 32'(grant_cnt[15:0]), 32'd0);
      check("cnt_clr1", 32'(grant_cnt[31:16]), 32'd0);
`endif

      req_valid = '0;
      do_reset();
      check("final_valid", 32'(rsp_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
